// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, queue entry type and zero-register constant for the write-back queue
package wb_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/wb_queue_mem.sv
// wb_queue_mem: DEPTH-entry write-back storage with head read and per-entry valid vector
module wb_queue_mem import wb_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   wptr,
    input  wb_entry_t                  wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   rptr,
    output wb_entry_t                  head,
    output wb_entry_t                  entries [DEPTH],
    output logic [DEPTH-1:0]           valid
);
    always_ff @(posedge clk)
        if (we) entries[wptr] <= wdata;
    always_ff @(posedge clk) begin
        if (rst) valid <= '0;
        else begin
            if (we) valid[wptr] <= 1'b1;
            if (re) valid[rptr] <= 1'b0;
        end
    end
    assign head = entries[rptr];
endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: write-back queue with RAW forwarding; WB_DROP_R0_EN drops address-0 writes
module regfile_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = wb_pkg::ADDR_W,
    parameter int DATA_W = wb_pkg::DATA_W
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic [ADDR_W-1:0]        In_Addr,
    input  logic [DATA_W-1:0]        In_Data,
    input  logic                     Gnt,
    output logic [ADDR_W-1:0]        Awr,
    output logic [DATA_W-1:0]        Din,
    output logic                     WrEn,
    input  logic [ADDR_W-1:0]        Ard1,
    input  logic [ADDR_W-1:0]        Ard2,
    output logic                     Fwd1_Hit,
    output logic [DATA_W-1:0]        Fwd1_Data,
    output logic                     Fwd2_Hit,
    output logic [DATA_W-1:0]        Fwd2_Data,
    output logic [$clog2(DEPTH):0]   Count
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] wptr, rptr;
    logic push, pop;
    wb_pkg::wb_entry_t wdata, head;
    wb_pkg::wb_entry_t entries [DEPTH];
    logic [DEPTH-1:0] valid;
    assign In_Ready = !Rst && !Count[PW];
    assign pop = Gnt && Count != '0;
    assign wdata = '{addr: In_Addr, data: In_Data};
`ifdef WB_DROP_R0_EN
    assign push = In_Valid && In_Ready && In_Addr != wb_pkg::ZERO_REG;
`else
    assign push = In_Valid && In_Ready;
`endif
    wb_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk(Clk), .rst(Rst), .we(push), .wptr(wptr), .wdata(wdata),
        .re(pop), .rptr(rptr), .head(head), .entries(entries), .valid(valid)
    );
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr  <= '0;
            rptr  <= '0;
            Count <= '0;
            WrEn  <= 1'b0;
            Awr   <= '0;
            Din   <= '0;
        end else begin
            wptr  <= push ? wptr + PW'(1) : wptr;
            rptr  <= pop ? rptr + PW'(1) : rptr;
            Count <= Count + (PW+1)'(push) - (PW+1)'(pop);
            WrEn  <= pop;
            Awr   <= pop ? head.addr : Awr;
            Din   <= pop ? head.data : Din;
        end
    end
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
        logic [DATA_W:0] r;
        logic [PW-1:0] idx;
        r = (WrEn && Awr == a) ? {1'b1, Din} : '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rptr + PW'(k);
            if (valid[idx] && entries[idx].addr == a) r = {1'b1, entries[idx].data};
        end
        return (a == wb_pkg::ZERO_REG) ? '0 : r;
    endfunction
    assign {Fwd1_Hit, Fwd1_Data} = lookup(Ard1);
    assign {Fwd2_Hit, Fwd2_Data} = lookup(Ard2);
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed self-checking bench for regfile_wb_queue
module tb_regfile_wb_queue;
    logic clk = 0, rst = 1, in_valid = 0, gnt = 0;
    logic in_ready, wr_en, fwd1_hit, fwd2_hit;
    logic [4:0] in_addr = 0, awr, ard1 = 0, ard2 = 0;
    logic [31:0] in_data = 0, din, fwd1_data, fwd2_data;
    logic [2:0] count;
    logic [36:0] mq[$];
    logic [36:0] e;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    regfile_wb_queue dut (
        .Clk(clk), .Rst(rst), .In_Valid(in_valid), .In_Ready(in_ready),
        .In_Addr(in_addr), .In_Data(in_data), .Gnt(gnt), .Awr(awr), .Din(din),
        .WrEn(wr_en), .Ard1(ard1), .Ard2(ard2), .Fwd1_Hit(fwd1_hit),
        .Fwd1_Data(fwd1_data), .Fwd2_Hit(fwd2_hit), .Fwd2_Data(fwd2_data), .Count(count)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        rst = 1;
        tick();
        tick();
        checks++; if (count !== 0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (wr_en !== 0) begin failures++; $display("FAIL reset_wren got=%0b exp=0", wr_en); end
        checks++; if (awr !== 0 || din !== 0) begin failures++; $display("FAIL reset_awr_din got=%0d/%h exp=0/0", awr, din); end
        checks++; if (in_ready !== 0) begin failures++; $display("FAIL reset_inready got=%0b exp=0", in_ready); end
        checks++; if (fwd1_hit !== 0 || fwd1_data !== 0) begin failures++; $display("FAIL reset_fwd1 got=%0b/%h exp=0/0", fwd1_hit, fwd1_data); end
        rst = 0;
        #1;
        checks++; if (in_ready !== 1) begin failures++; $display("FAIL post_reset_inready got=%0b exp=1", in_ready); end
    endtask
    task automatic test_single;
        gnt = 1; in_valid = 1; in_addr = 3; in_data = 32'hDEADBEEF;
        tick();
        in_valid = 0;
        checks++; if (count !== 1 || wr_en !== 0) begin failures++; $display("FAIL single_n1 got=count%0d/wren%0b exp=1/0", count, wr_en); end
        tick();
        checks++; if (wr_en !== 1 || awr !== 3 || din !== 32'hDEADBEEF) begin failures++; $display("FAIL single_write got=%0b/%0d/%h exp=1/3/deadbeef", wr_en, awr, din); end
        checks++; if (count !== 0) begin failures++; $display("FAIL single_count got=%0d exp=0", count); end
        tick();
        checks++; if (wr_en !== 0 || awr !== 3) begin failures++; $display("FAIL single_hold got=%0b/%0d exp=0/3", wr_en, awr); end
    endtask
    task automatic test_fill_drain;
        gnt = 0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1; in_addr = 5'(i); in_data = 32'(i * 32'h11);
            tick();
        end
        checks++; if (count !== 4 || in_ready !== 0) begin failures++; $display("FAIL full_state got=%0d/%0b exp=4/0", count, in_ready); end
        in_addr = 9; in_data = 32'h99;
        tick();
        in_valid = 0;
        checks++; if (count !== 4) begin failures++; $display("FAIL fifth_refused got=%0d exp=4", count); end
        gnt = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (wr_en !== 1 || awr !== 5'(i) || din !== 32'(i * 32'h11)) begin failures++; $display("FAIL drain_%0d got=%0b/%0d/%h exp=1/%0d/%h", i, wr_en, awr, din, i, i * 32'h11); end
        end
        tick();
        checks++; if (wr_en !== 0 || count !== 0) begin failures++; $display("FAIL drain_end got=%0b/%0d exp=0/0", wr_en, count); end
        gnt = 0;
    endtask
    task automatic test_forward;
        gnt = 0; in_valid = 1; in_addr = 5; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_valid = 0; ard1 = 5; ard2 = 6;
        #1;
        checks++; if (fwd1_hit !== 1 || fwd1_data !== 32'hB) begin failures++; $display("FAIL fwd1_young got=%0b/%h exp=1/b", fwd1_hit, fwd1_data); end
        checks++; if (fwd2_hit !== 0 || fwd2_data !== 0) begin failures++; $display("FAIL fwd2_miss got=%0b/%h exp=0/0", fwd2_hit, fwd2_data); end
        gnt = 1;
        tick();
        checks++; if (fwd1_hit !== 1 || fwd1_data !== 32'hB || din !== 32'hA) begin failures++; $display("FAIL fwd_queue_over_out got=%0b/%h/%h exp=1/b/a", fwd1_hit, fwd1_data, din); end
        tick();
        checks++; if (fwd1_hit !== 1 || fwd1_data !== 32'hB || count !== 0) begin failures++; $display("FAIL fwd_outreg got=%0b/%h/%0d exp=1/b/0", fwd1_hit, fwd1_data, count); end
        gnt = 0;
        tick();
        checks++; if (fwd1_hit !== 0 || fwd1_data !== 0) begin failures++; $display("FAIL fwd_gone got=%0b/%h exp=0/0", fwd1_hit, fwd1_data); end
        ard1 = 0; ard2 = 0;
    endtask
    task automatic test_back_to_back;
        gnt = 0; mq.delete();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_addr = 5'(10 + i); in_data = 32'h100 + 32'(i);
            mq.push_back({in_addr, in_data});
            tick();
        end
        gnt = 1; in_addr = 20; in_data = 32'h200;
        tick();
        e = mq.pop_front();
        checks++; if (count !== 3 || wr_en !== 1 || awr !== 10) begin failures++; $display("FAIL full_pop_nopush got=%0d/%0b/%0d exp=3/1/10", count, wr_en, awr); end
        gnt = 0;
        mq.push_back({in_addr, in_data});
        tick();
        in_valid = 0;
        checks++; if (count !== 4) begin failures++; $display("FAIL push_next_cycle got=%0d exp=4", count); end
        gnt = 1;
        tick();
        e = mq.pop_front();
        checks++; if (wr_en !== 1 || {awr, din} !== e) begin failures++; $display("FAIL pre_wrap got=%0b/%h exp=1/%h", wr_en, {awr, din}, e); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_addr = 5'((i % 8) + 1); in_data = 32'hC0DE0000 + 32'(i);
            mq.push_back({in_addr, in_data});
            tick();
            e = mq.pop_front();
            checks++; if (wr_en !== 1 || {awr, din} !== e || count !== 3) begin failures++; $display("FAIL wrap_%0d got=%0b/%h/%0d exp=1/%h/3", i, wr_en, {awr, din}, count, e); end
        end
        in_valid = 0;
        for (int i = 0; i < 10 && mq.size() > 0; i++) begin
            tick();
            e = mq.pop_front();
            checks++; if (wr_en !== 1 || {awr, din} !== e) begin failures++; $display("FAIL wrap_drain_%0d got=%0b/%h exp=1/%h", i, wr_en, {awr, din}, e); end
        end
        tick();
        checks++; if (count !== 0 || wr_en !== 0 || mq.size() != 0) begin failures++; $display("FAIL wrap_end got=%0d/%0b/%0d exp=0/0/0", count, wr_en, mq.size()); end
        gnt = 0;
    endtask
    task automatic test_reset_mid;
        gnt = 0; in_valid = 1; in_addr = 7; in_data = 32'h77;
        tick();
        in_addr = 8; in_data = 32'h88;
        tick();
        in_valid = 0; gnt = 1;
        tick();
        checks++; if (count !== 1 || wr_en !== 1) begin failures++; $display("FAIL mid_setup got=%0d/%0b exp=1/1", count, wr_en); end
        rst = 1; ard1 = 8; ard2 = 7;
        tick();
        checks++; if (count !== 0 || wr_en !== 0 || fwd1_hit !== 0 || fwd2_hit !== 0) begin failures++; $display("FAIL mid_reset got=%0d/%0b/%0b/%0b exp=0/0/0/0", count, wr_en, fwd1_hit, fwd2_hit); end
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (wr_en !== 0 || count !== 0 || fwd1_hit !== 0) begin failures++; $display("FAIL mid_stale_%0d got=%0b/%0d/%0b exp=0/0/0", i, wr_en, count, fwd1_hit); end
        end
        gnt = 0; ard1 = 0; ard2 = 0;
    endtask
    task automatic test_r0;
        gnt = 1; in_valid = 1; in_addr = 0; in_data = 32'h55; ard1 = 0;
        tick();
        in_valid = 0;
        checks++; if (fwd1_hit !== 0) begin failures++; $display("FAIL r0_fwd_q got=%0b exp=0", fwd1_hit); end
`ifdef WB_DROP_R0_EN
        checks++; if (count !== 0) begin failures++; $display("FAIL r0_count got=%0d exp=0", count); end
        tick();
        checks++; if (wr_en !== 0) begin failures++; $display("FAIL r0_wren got=%0b exp=0", wr_en); end
`else
        checks++; if (count !== 1) begin failures++; $display("FAIL r0_count got=%0d exp=1", count); end
        tick();
        checks++; if (wr_en !== 1 || awr !== 0 || din !== 32'h55) begin failures++; $display("FAIL r0_write got=%0b/%0d/%h exp=1/0/55", wr_en, awr, din); end
`endif
        checks++; if (fwd1_hit !== 0) begin failures++; $display("FAIL r0_fwd_out got=%0b exp=0", fwd1_hit); end
        tick();
        checks++; if (wr_en !== 0 || count !== 0) begin failures++; $display("FAIL r0_end got=%0b/%0d exp=0/0", wr_en, count); end
        gnt = 0;
    endtask
    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_forward();
        test_back_to_back();
        test_reset_mid();
        test_r0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Writer-side companion to the 32x32 register file: buffers write-back requests from the datapath and drains them, one per cycle, into the regfile write port (Awr/Din/WrEn).
- Supplies read-after-write forwarding for the two regfile read addresses (Ard1/Ard2) while a write is still queued or in flight.
- Sits between the execute/memory stages and the register file.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous active-high reset.
- In_Valid  in  1  write-back request valid.
- In_Ready  out  1  queue can accept; handshake completes when In_Valid && In_Ready at a rising edge.
- In_Addr  in  ADDR_W  destination register.
- In_Data  in  DATA_W  write data.
- Gnt  in  1  regfile write port available this cycle; head may pop only when high.
- Awr  out  ADDR_W  regfile write address (registered).
- Din  out  DATA_W  regfile write data (registered).
- WrEn  out  1  regfile write enable (registered).
- Ard1  in  ADDR_W  forwarding lookup address 1 (same net as regfile Ard1).
- Ard2  in  ADDR_W  forwarding lookup address 2.
- Fwd1_Hit  out  1  pending write to Ard1 exists.
- Fwd1_Data  out  DATA_W  youngest pending data for Ard1; 0 when no hit.
- Fwd2_Hit  out  1  as Fwd1_Hit, for Ard2.
- Fwd2_Data  out  DATA_W  as Fwd1_Data, for Ard2.
- Count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (Rst high at an edge):
  - count = 0, read/write pointers = 0.
  - WrEn = 0, Awr = 0, Din = 0.
  - Fwd*_Hit = 0, Fwd*_Data = 0.
  - In_Ready = 0 while Rst is high; 1 in the first cycle after Rst deasserts.
- Reset mid-operation: all queued entries and the in-flight output register are discarded; no WrEn pulse follows.
- In_Ready:
  - In_Ready = (Count < DEPTH), independent of pop in the same cycle.
  - When full, a simultaneous pop does not admit a push in that cycle.
- Push: on an edge with In_Valid && In_Ready, {In_Addr, In_Data} is written at the write pointer; the write pointer wraps modulo DEPTH.
- Pop: on an edge with Gnt && Count>0, the head is moved into the output register: WrEn=1, Awr=head addr, Din=head data for exactly the next cycle. The read pointer wraps modulo DEPTH.
- If there is no pop at an edge, WrEn=0 next cycle and Awr/Din hold their last values.
- Latency: push at edge N, with an empty queue and Gnt high, gives WrEn=1 during cycle N+1..N+2, so the regfile commits at edge N+2.
- Simultaneous push and pop: Count is unchanged and both pointers advance.
- Ordering: strict FIFO; duplicate addresses are all written, in order.
- Forwarding (combinational from Ard*):
  - Candidates are the valid queue entries plus the output register when WrEn=1.
  - Priority is youngest queue entry first, then older queue entries, then the output register.
  - Ard*=0 never hits.
  - An entry pushed at the current edge is visible from the next cycle.
- Count counts queue entries only; the output register is excluded.

Optional Feature:
- Macro: WB_DROP_R0_EN.
- Defined: a handshake with In_Addr=0 completes (In_Ready as normal) but is not enqueued; Count is unchanged and no WrEn is ever issued for it.
- Undefined: address-0 writes are enqueued and drained normally. The regfile ignores them, and forwarding still never hits on address 0.

Decomposition:
- Package wb_pkg holds:
  - ADDR_W and DATA_W constants.
  - The wb_entry_t typedef {addr, data}.
  - A ZERO_REG constant (0).
- One sub-module, wb_queue_mem: DEPTH-entry storage with write port, head read port, and a per-entry valid vector exported for the forwarding compare. Pointer, count and output-register logic stay in the top.

Test Plan:
1. Reset, then push {3, 0xDEADBEEF} with Gnt=1 -> WrEn=1, Awr=3, Din=0xDEADBEEF exactly one cycle, two edges after the push; Count returns to 0.
2. Gnt=0, push {1,0x11},{2,0x22},{3,0x33},{4,0x44} -> Count=4, In_Ready=0; a fifth push is refused. Then Gnt=1 -> WrEn pulses over 4 consecutive cycles with Awr=1,2,3,4 in order.
3. Gnt=0, push {5,0xA},{5,0xB}; Ard1=5, Ard2=6 -> Fwd1_Hit=1, Fwd1_Data=0xB; Fwd2_Hit=0, Fwd2_Data=0.
4. Full queue with Gnt=1 and In_Valid=1 -> no push that cycle, Count drops to 3; push accepted next cycle; pointer wrap verified over 10 pushes with data intact.
5. Queue holding 2 entries, assert Rst for one edge -> Count=0, WrEn=0 thereafter, Fwd*_Hit=0; no stale writes issued.
6. Push {0, 0x55}: with WB_DROP_R0_EN, Count stays 0 and no WrEn; without it, WrEn=1 with Awr=0. In both builds Ard1=0 gives Fwd1_Hit=0.
